// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store and fetch controller for a byte-wide sync RAM.
// Optional fetch abort port: define MEMCTRL_FETCH_ABORT_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_type,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_done,
  output logic [DATA_W-1:0] resp_data,
  output logic              stall_req,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
`ifdef MEMCTRL_FETCH_ABORT_EN
  input  logic              if_abort,
`endif
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr
);

  typedef enum logic [2:0] {
    IDLE, DRD, DWR, FETCH, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [1:0]        type_q, type_d;
  logic              uns_q, uns_d;
  logic              fetch_q, fetch_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              abort;

`ifdef MEMCTRL_FETCH_ABORT_EN
  assign abort = if_abort & fetch_q;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] ext(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        t,
    input logic              u
  );
    logic [DATA_W-1:0] r;
    r = w;
    if (t == 2'b00) begin
      r = {{24{w[7] & ~u}}, w[7:0]};
    end else if (t == 2'b01) begin
      r = {{16{w[15] & ~u}}, w[15:0]};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      asm_q   <= '0;
      type_q  <= '0;
      uns_q   <= 1'b0;
      fetch_q <= 1'b0;
      rdata_q <= '0;
      inst_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      asm_q   <= asm_d;
      type_q  <= type_d;
      uns_q   <= uns_d;
      fetch_q <= fetch_d;
      rdata_q <= rdata_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    asm_d   = asm_q;
    type_d  = type_q;
    uns_d   = uns_q;
    fetch_d = fetch_q;
    rdata_d = rdata_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          type_d  = req_type;
          uns_d   = req_unsigned;
          fetch_d = 1'b0;
          cnt_d   = '0;
          asm_d   = '0;
          if (req_type == 2'b00) begin
            len_d = 3'd1;
          end else if (req_type == 2'b01) begin
            len_d = 3'd2;
          end else begin
            len_d = 3'd4;
          end
          state_d = req_wr ? DWR : DRD;
        end else if (if_req) begin
          addr_d  = if_addr;
          fetch_d = 1'b1;
          len_d   = 3'd4;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = FETCH;
        end
      end
      DWR: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRD, FETCH: begin
        // Read data lags the address by one beat.
        if (cnt_q != 3'd0) begin
          asm_d = asm_q
            | (DATA_W'(ram_din) << {cnt_q - 3'd1, 3'b000});
        end
        if (cnt_q == len_q) begin
          state_d = DONE;
          if (fetch_q) begin
            inst_d = asm_d;
          end else begin
            rdata_d = ext(asm_d, type_q, uns_q);
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          inst_d  = inst_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    resp_done = (state_q == DONE) & ~fetch_q;
    if_done   = (state_q == DONE) & fetch_q & ~abort;
    stall_req = req_valid & ~resp_done;
    resp_data = rdata_q;
    if_inst   = inst_q;
    ram_addr  = addr_q + ADDR_W'(cnt_q);
    ram_wr    = (state_q == DWR) & rdy;
    ram_dout  = 8'h00;
    if (state_q == DWR) begin
      case (cnt_q[1:0])
        2'd0:    ram_dout = data_q[7:0];
        2'd1:    ram_dout = data_q[15:8];
        2'd2:    ram_dout = data_q[23:16];
        default: ram_dout = data_q[31:24];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table, scoreboard on done pulses,
// and cycle-exact sequences for arbitration, reset and rdy freeze.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        req_valid, req_wr, req_unsigned;
  logic [1:0]  req_type;
  logic [31:0] req_addr, req_data;
  logic        resp_done, stall_req;
  logic [31:0] resp_data;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_inst;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
`ifdef MEMCTRL_FETCH_ABORT_EN
  logic        if_abort;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_type(req_type),
    .req_unsigned(req_unsigned), .req_data(req_data),
    .resp_done(resp_done), .resp_data(resp_data),
    .stall_req(stall_req),
    .if_req(if_req), .if_addr(if_addr),
`ifdef MEMCTRL_FETCH_ABORT_EN
    .if_abort(if_abort),
`endif
    .if_done(if_done), .if_inst(if_inst),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  // RAM model; global rdy also freezes its read register
  logic [7:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] = ram_dout;
    if (rdy) ram_din <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  typ;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] dat;
    int          lat;
  } vec_t;

  typedef struct {
    logic        on;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] ifq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && resp_done) begin
      if (sbq.size() == 0) begin
        chk("sb data unexpected done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (e.on) chk("sb resp_data", resp_data, e.exp);
      end
    end
    if (rst && if_done) begin
      if (ifq.size() == 0) begin
        chk("sb fetch unexpected done", 32'd1, 32'd0);
      end else begin
        logic [31:0] x;
        x = ifq.pop_front();
        chk("sb if_inst", if_inst, x);
      end
    end
  end

  task automatic drive(input vec_t v);
    req_wr       = v.wr;
    req_type     = v.typ;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_data     = v.wr ? v.dat : 32'h0;
    req_valid    = 1'b1;
  endtask

  task automatic run_req(input vec_t v, input string nm);
    int got;
    got = 0;
    drive(v);
    sbq.push_back('{on: ~v.wr, exp: v.dat});
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (resp_done) begin
        got = c;
        break;
      end
    end
    req_valid = 1'b0;
    chk({nm, " latency"}, 32'(got), 32'(v.lat));
    @(posedge clk); #1;
    chk({nm, " pulse width"}, {31'b0, resp_done}, 32'd0);
  endtask

  vec_t vt[13];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int dc, fc;
    rst = 1'b0; rdy = 1'b1;
    req_valid = 0; req_wr = 0; req_unsigned = 0;
    req_type = 0; req_addr = 0; req_data = 0;
    if_req = 0; if_addr = 0;
`ifdef MEMCTRL_FETCH_ABORT_EN
    if_abort = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst resp_done", {31'b0, resp_done}, 0);
    chk("rst resp_data", resp_data, 0);
    chk("rst if_done", {31'b0, if_done}, 0);
    chk("rst if_inst", if_inst, 0);
    chk("rst ram_wr", {31'b0, ram_wr}, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_dout", {24'b0, ram_dout}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    vt[0]  = '{1, 2'b10, 0, 32'h0000_1000, 32'h1234_5678, 5};
    vt[1]  = '{0, 2'b10, 0, 32'h0000_1000, 32'h1234_5678, 6};
    vt[2]  = '{1, 2'b00, 0, 32'h0000_2000, 32'h0000_0080, 2};
    vt[3]  = '{0, 2'b00, 0, 32'h0000_2000, 32'hFFFF_FF80, 3};
    vt[4]  = '{0, 2'b00, 1, 32'h0000_2000, 32'h0000_0080, 3};
    vt[5]  = '{1, 2'b01, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 3};
    vt[6]  = '{0, 2'b01, 1, 32'hFFFF_FFFF, 32'h0000_BEEF, 4};
    vt[7]  = '{0, 2'b01, 0, 32'hFFFF_FFFF, 32'hFFFF_BEEF, 4};
    vt[8]  = '{0, 2'b10, 0, 32'hFFFF_FFFE, 32'h00BE_EF00, 6};
    vt[9]  = '{1, 2'b10, 0, 32'h0000_3001, 32'hA5A5_0001, 5};
    vt[10] = '{0, 2'b11, 1, 32'h0000_3001, 32'hA5A5_0001, 6};
    vt[11] = '{0, 2'b01, 0, 32'h0000_3003, 32'hFFFF_A5A5, 4};
    vt[12] = '{0, 2'b00, 0, 32'h0000_3001, 32'h0000_0001, 3};
    for (int i = 0; i < 13; i++) begin
      run_req(vt[i], $sformatf("vec%0d", i));
    end

    // word load, cycle by cycle
    v = '{0, 2'b10, 0, 32'h0000_1000, 32'h1234_5678, 6};
    drive(v);
    sbq.push_back('{on: 1'b1, exp: v.dat});
    #1 chk("wl stall c0", {31'b0, stall_req}, 1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("wl stall c%0d", c),
          {31'b0, stall_req}, {31'b0, c <= 5});
      chk($sformatf("wl done c%0d", c),
          {31'b0, resp_done}, {31'b0, c == 6});
      if (c <= 4)
        chk($sformatf("wl addr c%0d", c),
            ram_addr, 32'h1000 + 32'(c - 1));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    // halfword store wrapping past the top of memory
    v = '{1, 2'b01, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 3};
    drive(v);
    sbq.push_back('{on: 1'b0, exp: 32'h0});
    @(posedge clk); #1;
    chk("hs c1 wr", {31'b0, ram_wr}, 1);
    chk("hs c1 addr", ram_addr, 32'hFFFF_FFFF);
    chk("hs c1 dout", {24'b0, ram_dout}, 32'hEF);
    @(posedge clk); #1;
    chk("hs c2 wr", {31'b0, ram_wr}, 1);
    chk("hs c2 addr", ram_addr, 32'h0);
    chk("hs c2 dout", {24'b0, ram_dout}, 32'hBE);
    @(posedge clk); #1;
    chk("hs c3 done", {31'b0, resp_done}, 1);
    chk("hs c3 wr", {31'b0, ram_wr}, 0);
    chk("hs c3 dout", {24'b0, ram_dout}, 0);
    req_valid = 1'b0;
    chk("hs byte2 untouched", {31'b0, mem.exists(32'h1)}, 0);
    @(posedge clk); #1;

    // data and fetch together: data wins, fetch follows
    v = '{0, 2'b00, 0, 32'h0000_2000, 32'hFFFF_FF80, 3};
    drive(v);
    sbq.push_back('{on: 1'b1, exp: v.dat});
    if_req = 1'b1; if_addr = 32'h1000;
    ifq.push_back(32'h1234_5678);
    dc = 0; fc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (resp_done) begin
        dc = c;
        req_valid = 1'b0;
      end
      if (if_done) begin
        fc = c;
        if_req = 1'b0;
        break;
      end
    end
    chk("arb data done cycle", 32'(dc), 3);
    chk("arb fetch done cycle", 32'(fc), 10);
    @(posedge clk); #1;
    chk("arb if_done single", {31'b0, if_done}, 0);

    // data request arriving mid-fetch waits for it
    if_req = 1'b1; if_addr = 32'h3001;
    ifq.push_back(32'hA5A5_0001);
    dc = 0; fc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        v = '{0, 2'b00, 1, 32'h0000_3003, 32'h0000_00A5, 3};
        drive(v);
        sbq.push_back('{on: 1'b1, exp: v.dat});
        #1 chk("blk stall", {31'b0, stall_req}, 1);
      end
      if (if_done) begin
        fc = c;
        if_req = 1'b0;
      end
      if (resp_done) begin
        dc = c;
        req_valid = 1'b0;
        break;
      end
    end
    chk("blk fetch done cycle", 32'(fc), 6);
    chk("blk data done cycle", 32'(dc), 10);
    @(posedge clk); #1;

    // reset during beat 2 of a word store
    v = '{1, 2'b10, 0, 32'h0000_4000, 32'hCAFE_BABE, 5};
    drive(v);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstm ram_wr", {31'b0, ram_wr}, 0);
    chk("rstm done", {31'b0, resp_done}, 0);
    chk("rstm resp_data", resp_data, 0);
    chk("rstm ram_addr", ram_addr, 0);
    rst = 1'b1;
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rstm no done", {31'b0, resp_done}, 0);
    end
    v = '{0, 2'b10, 0, 32'h0000_4000, 32'h00FE_BABE, 6};
    run_req(v, "rstm readback");

    // rdy low for three cycles in the middle of a word load
    v = '{0, 2'b10, 0, 32'h0000_1000, 32'h1234_5678, 9};
    fork
      run_req(v, "frz");
      begin
        @(posedge clk);
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("frz addr hold", ram_addr, 32'h1001);
        @(posedge clk); #1;
        rdy = 1'b1;
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("sb data drained", 32'(sbq.size()), 0);
    chk("sb fetch drained", 32'(ifq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
